// File: rtl/bp_me_wormhole_packet_decode_mem_resp.sv
// Memory-response wormhole decoder: reassembles flit-serial packets into one CCE memory message.
// Optional build macro BP_ME_WH_DECODE_LEN_CHECK_EN adds a sticky header-vs-len consistency check.

package bp_me_wormhole_packet_decode_mem_resp_pkg;

  localparam int msg_type_width_gp = 4;
  localparam int msg_size_width_gp = 3;

  typedef enum logic [msg_type_width_gp-1:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_pre   = 4'd4
  } bp_cce_mem_cmd_e;

endpackage

module bp_me_wormhole_packet_decode_mem_resp
  import bp_me_wormhole_packet_decode_mem_resp_pkg::*;
#(
  // Processor configuration, expressed as the widths it supplies
  parameter int paddr_width_p     = 40,
  parameter int cce_block_width_p = 512,
  parameter int lce_id_width_p    = 4,
  parameter int lce_assoc_p       = 8,
  parameter int flit_width_p      = 128,
  parameter int cord_width_p      = 4,
  parameter int cid_width_p       = 2,
  parameter int len_width_p       = 4,

  localparam int way_width_lp         = $clog2(lce_assoc_p),
  localparam int hdr_width_lp         = msg_type_width_gp + msg_size_width_gp + paddr_width_p
                                        + lce_id_width_p + way_width_lp,
  localparam int cce_mem_msg_width_lp = hdr_width_lp + cce_block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,

  input  logic [flit_width_p-1:0]         flit_i,
  input  logic                            flit_v_i,
  output logic                            flit_ready_and_o,

  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic [cord_width_p-1:0]         src_cord_o,
  output logic [cid_width_p-1:0]          src_cid_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i,

  output logic                            error_o
);

  // Packet field offsets, LSB first: cord, len, cid, src_cord, src_cid, header, data
  localparam int len_off_lp      = cord_width_p;
  localparam int src_cord_off_lp = cord_width_p + len_width_p + cid_width_p;
  localparam int src_cid_off_lp  = src_cord_off_lp + cord_width_p;
  localparam int routing_width_lp = src_cid_off_lp + cid_width_p;
  localparam int packet_width_lp = routing_width_lp + cce_mem_msg_width_lp;
  localparam int max_flits_lp    = (packet_width_lp + flit_width_p - 1) / flit_width_p;
  localparam int buf_width_lp    = max_flits_lp * flit_width_p;
  localparam int idx_width_lp    = len_width_p + 1;

  typedef enum logic [1:0] {
    e_ready,
    e_body,
    e_valid
  } state_e;

  state_e                  state_r;
  logic [len_width_p-1:0]  count_r;
  logic [len_width_p-1:0]  len_r;
  logic [buf_width_lp-1:0] buf_r;
  logic                    ready_r;
  logic                    v_r;

  logic                    flit_accept;
  logic [len_width_p-1:0]  head_len;
  logic [idx_width_lp-1:0] body_idx;

  assign flit_accept = flit_v_i & ready_r;
  assign head_len    = flit_i[len_off_lp +: len_width_p];
  // Position of the incoming body flit: flits already taken = len - count, plus the head
  assign body_idx    = idx_width_lp'(len_r) - idx_width_lp'(count_r) + idx_width_lp'(1);

  // NOTE: the assembly buffer is a plain register that is reset, so a packet cut short
  // by reset can never leak stale bits into the next message.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
      count_r <= '0;
      len_r   <= '0;
      buf_r   <= '0;
      ready_r <= 1'b1;
      v_r     <= 1'b0;
    end else begin
      // NOTE: every sequential update uses <= so all flops sample the same pre-edge values.
      case (state_r)
        e_ready: begin
          if (flit_accept) begin
            buf_r   <= buf_width_lp'(flit_i);
            len_r   <= head_len;
            count_r <= head_len;
            if (head_len == '0) begin
              state_r <= e_valid;
              ready_r <= 1'b0;
              v_r     <= 1'b1;
            end else begin
              state_r <= e_body;
            end
          end
        end

        e_body: begin
          if (flit_accept) begin
            // Indices past the buffer match no slot and are simply dropped
            for (int k = 1; k < max_flits_lp; k++) begin
              if (int'(body_idx) == k) begin
                buf_r[k*flit_width_p +: flit_width_p] <= flit_i;
              end
            end
            count_r <= count_r - len_width_p'(1);
            if (count_r == len_width_p'(1)) begin
              state_r <= e_valid;
              ready_r <= 1'b0;
              v_r     <= 1'b1;
            end
          end
        end

        e_valid: begin
          if (mem_resp_yumi_i) begin
            state_r <= e_ready;
            ready_r <= 1'b1;
            v_r     <= 1'b0;
          end
        end

        default: begin
          state_r <= e_ready;
          ready_r <= 1'b1;
          v_r     <= 1'b0;
        end
      endcase
    end
  end

  assign flit_ready_and_o = ready_r;
  assign mem_resp_v_o     = v_r;
  assign mem_resp_o       = buf_r[routing_width_lp +: cce_mem_msg_width_lp];
  assign src_cord_o       = buf_r[src_cord_off_lp +: cord_width_p];
  assign src_cid_o        = buf_r[src_cid_off_lp +: cid_width_p];

`ifdef BP_ME_WH_DECODE_LEN_CHECK_EN
  localparam int hdr_bits_lp = packet_width_lp - cce_block_width_p;
  localparam int msg_type_off_lp = routing_width_lp;
  localparam int msg_size_off_lp = routing_width_lp + msg_type_width_gp + paddr_width_p;

  logic                         chk_pend_r;
  logic                         error_r;
  logic                         len_ok;
  logic [msg_type_width_gp-1:0] msg_type;
  logic [msg_size_width_gp-1:0] msg_size;
  logic [len_width_p-1:0]       rx_len;
  int                           exp_len;

  assign msg_type = buf_r[msg_type_off_lp +: msg_type_width_gp];
  assign msg_size = buf_r[msg_size_off_lp +: msg_size_width_gp];
  assign rx_len   = buf_r[len_off_lp +: len_width_p];

  always_comb begin
    exp_len = 0;
    len_ok  = 1'b0;
    case (msg_type)
      e_cce_mem_rd, e_cce_mem_uc_rd: begin
        // Reads carry 2^size bytes of data; sizes beyond a full block are malformed
        if (msg_size <= msg_size_width_gp'(6)) begin
          exp_len = (hdr_bits_lp + (8 << msg_size) + flit_width_p - 1) / flit_width_p - 1;
          len_ok  = (int'(rx_len) == exp_len);
        end
      end
      e_cce_mem_wr, e_cce_mem_uc_wr, e_cce_mem_pre: begin
        exp_len = (hdr_bits_lp + flit_width_p - 1) / flit_width_p - 1;
        len_ok  = (int'(rx_len) == exp_len);
      end
      default: len_ok = 1'b0;
    endcase
  end

  // The buffer is final only once e_valid is entered, so the check runs in its first cycle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      chk_pend_r <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      if (state_r != e_valid && flit_accept &&
          ((state_r == e_ready && head_len == '0) ||
           (state_r == e_body  && count_r == len_width_p'(1)))) begin
        chk_pend_r <= 1'b1;
      end else if (state_r == e_valid && chk_pend_r) begin
        chk_pend_r <= 1'b0;
        if (!len_ok) error_r <= 1'b1;
      end
    end
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

  // Routing fields and buffer padding are carried but not presented downstream
  logic unused_buf;
  assign unused_buf = ^buf_r;

endmodule

// File: tb/tb_bp_me_wormhole_packet_decode_mem_resp.sv
// Directed bench for the memory-response wormhole decoder with hand-built packets.

module tb_bp_me_wormhole_packet_decode_mem_resp;
  import bp_me_wormhole_packet_decode_mem_resp_pkg::*;

  // Default configuration: header 54 b, routing 16 b, packet 582 b, five 128-b flits
  localparam int flit_w = 128;
  localparam int msg_w  = 566;
  localparam int buf_w  = 640;

  logic              clk;
  logic              rst_n;
  logic [flit_w-1:0] flit;
  logic              flit_v;
  logic              flit_ready_and_o;
  logic [msg_w-1:0]  mem_resp_o;
  logic [3:0]        src_cord_o;
  logic [1:0]        src_cid_o;
  logic              mem_resp_v_o;
  logic              yumi;
  logic              error_o;

  int n_checks = 0;
  int pass_cnt = 0;

  bp_me_wormhole_packet_decode_mem_resp dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .flit_i           (flit),
    .flit_v_i         (flit_v),
    .flit_ready_and_o (flit_ready_and_o),
    .mem_resp_o       (mem_resp_o),
    .src_cord_o       (src_cord_o),
    .src_cid_o        (src_cid_o),
    .mem_resp_v_o     (mem_resp_v_o),
    .mem_resp_yumi_i  (yumi),
    .error_o          (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [buf_w-1:0] obs, input logic [buf_w-1:0] exp);
    n_checks++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [53:0] mk_hdr(input logic [3:0] t, input logic [39:0] a,
                                         input logic [2:0] s, input logic [6:0] p);
    return {p, s, a, t};
  endfunction

  // Layout LSB first: cord=2, len, cid=1, src_cord, src_cid, header, data, zero padding
  function automatic logic [buf_w-1:0] mk_pkt(input logic [3:0] len, input logic [3:0] scord,
                                              input logic [1:0] scid, input logic [53:0] hdr,
                                              input logic [511:0] data);
    return {58'd0, data, hdr, scid, scord, 2'd1, len, 4'd2};
  endfunction

  // Expected message: only the first nflits flits of the packet exist, the rest read as zero
  function automatic logic [msg_w-1:0] exp_resp(input logic [buf_w-1:0] p, input int nflits);
    logic [buf_w-1:0] m;
    m = '0;
    for (int i = 0; i < nflits * flit_w; i++) m[i] = p[i];
    return m[16 +: msg_w];
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic send_flit(input logic [flit_w-1:0] f);
    int n;
    n = 0;
    flit_v = 1'b1;
    flit   = f;
    while (!flit_ready_and_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("ready_timeout", flit_ready_and_o, 1);
    @(posedge clk); #1;
    flit_v = 1'b0;
  endtask

  task automatic send_pkt(input logic [buf_w-1:0] p, input int nflits, input int gap);
    for (int k = 0; k < nflits; k++) begin
      send_flit(p[k*flit_w +: flit_w]);
      if (k < nflits - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic take();
    yumi = 1'b1;
    @(posedge clk); #1;
    yumi = 1'b0;
  endtask

  logic [buf_w-1:0] pkt_a, pkt_b, pkt_c, pkt_d, pkt_e;
  logic [msg_w-1:0] exp_c;
  logic [53:0]      hdr;

  initial begin
    rst_n  = 1'b0;
    flit   = '0;
    flit_v = 1'b0;
    yumi   = 1'b0;
    #12;
    check("rst_ready", flit_ready_and_o, 1);
    check("rst_v", mem_resp_v_o, 0);
    check("rst_resp", mem_resp_o, 0);
    check("rst_src", {src_cord_o, src_cid_o}, 0);
    check("rst_err", error_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-flit write ack
    hdr   = mk_hdr(e_cce_mem_wr, 40'h12_3456_78ab, 3'd6, 7'h55);
    pkt_a = mk_pkt(4'd0, 4'hc, 2'd3, hdr, '0);
    send_pkt(pkt_a, 1, 0);
    check("ack_v", mem_resp_v_o, 1);
    check("ack_ready", flit_ready_and_o, 0);
    check("ack_hdr", mem_resp_o[53:0], hdr);
    check("ack_data", mem_resp_o[msg_w-1:54], 0);
    check("ack_src", {src_cord_o, src_cid_o}, {4'hc, 2'd3});
    @(posedge clk); #1;
    check("ack_ready_hold", flit_ready_and_o, 0);
    take();
    check("ack_v_clr", mem_resp_v_o, 0);
    check("ack_ready_back", flit_ready_and_o, 1);

    // 64-byte read, len=4, back-to-back flits
    hdr   = mk_hdr(e_cce_mem_rd, 40'h00_dead_bee0, 3'd6, 7'h12);
    pkt_b = mk_pkt(4'd4, 4'h5, 2'd2, hdr, rand_block());
    for (int k = 0; k < 5; k++) begin
      send_flit(pkt_b[k*flit_w +: flit_w]);
      if (k == 3) check("rd_v_early", mem_resp_v_o, 0);
    end
    check("rd_v", mem_resp_v_o, 1);
    check("rd_resp", mem_resp_o, pkt_b[16 +: msg_w]);
    check("rd_src", {src_cord_o, src_cid_o}, {4'h5, 2'd2});
    take();

    // 32-byte uncached read over 3 flits, valid pattern 1,0,0,1,0,0,1
    hdr   = mk_hdr(e_cce_mem_uc_rd, 40'h80_0000_0040, 3'd5, 7'h01);
    pkt_c = mk_pkt(4'd2, 4'h9, 2'd1, hdr, rand_block());
    exp_c = exp_resp(pkt_c, 3);
    send_flit(pkt_c[0 +: flit_w]);
    repeat (2) begin @(posedge clk); #1; end
    send_flit(pkt_c[flit_w +: flit_w]);
    repeat (2) begin @(posedge clk); #1; end
    check("gap_v_early", mem_resp_v_o, 0);
    send_flit(pkt_c[2*flit_w +: flit_w]);
    check("gap_v", mem_resp_v_o, 1);
    check("gap_resp", mem_resp_o, exp_c);
    check("gap_src", {src_cord_o, src_cid_o}, {4'h9, 2'd1});

    // Backpressure: yumi withheld while the next head is already offered
    hdr   = mk_hdr(e_cce_mem_uc_wr, 40'h01_0203_0405, 3'd3, 7'h7f);
    pkt_d = mk_pkt(4'd0, 4'h3, 2'd0, hdr, '0);
    flit_v = 1'b1;
    flit   = pkt_d[0 +: flit_w];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_resp_stable", mem_resp_o, exp_c);
      check("bp_ready", flit_ready_and_o, 0);
      check("bp_v", mem_resp_v_o, 1);
    end
    take();
    check("bp_v_clr", mem_resp_v_o, 0);
    check("bp_ready_back", flit_ready_and_o, 1);
    @(posedge clk); #1;
    flit_v = 1'b0;
    check("bp_next_v", mem_resp_v_o, 1);
    check("bp_next_resp", mem_resp_o, exp_resp(pkt_d, 1));
    take();

    // Reset after 2 of 4 flits, then a clean single-flit packet
    hdr   = mk_hdr(e_cce_mem_rd, 40'h77_7777_7700, 3'd6, 7'h2a);
    pkt_e = mk_pkt(4'd3, 4'hf, 2'd3, hdr, rand_block());
    send_pkt(pkt_e, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", flit_ready_and_o, 1);
    check("mid_rst_v", mem_resp_v_o, 0);
    check("mid_rst_resp", mem_resp_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_pkt(pkt_a, 1, 0);
    check("post_rst_v", mem_resp_v_o, 1);
    check("post_rst_resp", mem_resp_o, exp_resp(pkt_a, 1));
    check("post_rst_src", {src_cord_o, src_cid_o}, {4'hc, 2'd3});
    take();

`ifdef BP_ME_WH_DECODE_LEN_CHECK_EN
    // 8-byte uncached read needs len=1; send len=2
    hdr   = mk_hdr(e_cce_mem_uc_rd, 40'h00_0000_1000, 3'd3, 7'h00);
    pkt_e = mk_pkt(4'd2, 4'h1, 2'd1, hdr, rand_block());
    send_pkt(pkt_e, 3, 0);
    take();
    check("len_err_set", error_o, 1);
    send_pkt(pkt_a, 1, 0);
    take();
    check("len_err_sticky", error_o, 1);
`else
    check("err_tied_low", error_o, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_me_wormhole_packet_decode_mem_resp.md
Name: bp_me_wormhole_packet_decode_mem_resp

Overview:
Receive-side counterpart of the memory-response wormhole encoder. Accepts a serial stream of wormhole flits from the memory NoC, reassembles one packet at a time, and presents a bp_cce_mem_msg_s (header + data) plus the sender's cord/cid to the CCE. Sits between the wormhole router output link and the CCE memory-response input. One packet buffer, flit-serial input, single-message output with a valid/yumi handshake.

Parameters:
bp_params_p, e_bp_inv_cfg, processor config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p and therefore cce_mem_msg_width_lp.
flit_width_p, "inv", wormhole flit width in bits.
cord_width_p, "inv", router coordinate width.
cid_width_p, "inv", concentrator id width.
len_width_p, "inv", packet length field width (flits minus one).
Derived: hdr_width_lp = cce_mem_msg_width_lp - cce_block_width_p; packet_width_lp = cord + len + cid + cord + cid + hdr_width_lp + cce_block_width_p; max_flits_lp = ceil(packet_width_lp / flit_width_p).

Ports:
clk_i  in  1  clock.
reset_n_i  in  1  asynchronous, active-low reset.
flit_i  in  flit_width_p  incoming flit.
flit_v_i  in  1  flit valid.
flit_ready_and_o  out  1  flit accepted when flit_v_i & flit_ready_and_o.
mem_resp_o  out  cce_mem_msg_width_lp  reassembled {data, header}.
src_cord_o  out  cord_width_p  sender cord from packet.
src_cid_o  out  cid_width_p  sender cid from packet.
mem_resp_v_o  out  1  message valid.
mem_resp_yumi_i  in  1  consumer takes message; only legal while mem_resp_v_o.
error_o  out  1  sticky length-check error (see Optional Feature).

Behaviour:
- Packet layout, LSB first: cord, len, cid, src_cord, src_cid, msg header, data. Flit k occupies packet bits [k*flit_width_p +: flit_width_p]; flit 0 is the head.
- Flits beyond the last one received read as zero; a shorter packet yields a zero-filled upper data field.
- Assembly buffer: max_flits_lp*flit_width_p bits, cleared on head acceptance. Remaining-flit counter: len_width_p bits.
- States:
  - e_ready: flit_ready_and_o=1. On head accept: store flit 0; counter <= len field.
    - len==0 -> e_valid.
    - else -> e_body.
  - e_body: flit_ready_and_o=1. Each accept stores the flit at index (len - counter + 1); counter decrements. Accepting the flit with counter==1 -> e_valid.
  - e_valid: flit_ready_and_o=0; mem_resp_v_o=1; outputs driven from the buffer. On mem_resp_yumi_i -> e_ready.
- Latency: mem_resp_v_o rises the cycle after the last flit is accepted. A new head can be accepted the cycle after yumi; no bubble beyond that.
- Throughput: one flit per cycle in e_ready/e_body. flit_v_i low simply stalls; the counter holds.
- Flits with len > max_flits_lp-1 are unsupported. Index writes past the buffer are dropped and must not corrupt lower bits.
- Reset (asynchronous, at any time including mid-packet): state=e_ready, counter=0, buffer=0, error_o=0. Outputs under reset: flit_ready_and_o=1, mem_resp_v_o=0, mem_resp_o/src_cord_o/src_cid_o=0. A partial packet is discarded.
- The cord/cid destination fields are not checked; routing is the router's job.
- Outputs are stable from valid until yumi.

Optional Feature:
BP_ME_WH_DECODE_LEN_CHECK_EN:
- Defined: on entry to e_valid, compute the expected len from the header.
  - msg_type e_cce_mem_rd/e_cce_mem_uc_rd: expected = ceil((packet_width_lp - cce_block_width_p + 8*2^size)/flit_width_p) - 1, with size 1..64 B.
  - e_cce_mem_wr/e_cce_mem_uc_wr/e_cce_mem_pre: expected = ceil((packet_width_lp - cce_block_width_p)/flit_width_p) - 1.
  - Other msg_type, or mismatch with the received len: error_o set and held until reset. The message is still delivered.
- Undefined: error_o tied 0 and no check logic is built.

Test Plan:
- Single-flit ack (len=0, e_cce_mem_wr): head accepted at cycle T -> mem_resp_v_o=1 at T+1; header matches; data=0; ready=0 until yumi.
- Read of 64 B, len=L: L+1 back-to-back flits -> data equals the original 512-bit block; src_cord_o/src_cid_o match the head fields; valid at the cycle after flit L.
- Gapped input: flit_v_i toggled 1,0,0,1,... on a 3-flit packet -> identical reassembly; counter holds on idle cycles.
- Backpressure: yumi withheld 5 cycles -> outputs stable, flit_ready_and_o=0; next packet's head is accepted the cycle after yumi.
- Reset asserted after 2 of 4 flits -> immediately e_ready with v=0. A following 1-flit packet is decoded cleanly with no stale data.
- With BP_ME_WH_DECODE_LEN_CHECK_EN: uc_rd size 8 sent with len = expected+1 -> error_o=1, stays set after further correct packets. Without the macro, error_o stays 0.
